mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan.sv | 64 ++++++
 tb/tb_mux_scan.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// Scanning channel multiplexer: registers one channel of a flattened input bus per clock,
// with a channel pointer that can be loaded directly or advanced automatically.
module mux_scan #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      load_sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      sel_err
);

    logic [WIDTH-1:0] ch_data [CHANNELS];
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic             sel_ok;
    logic             ptr_last;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign ch_data[k] = in[k*WIDTH +: WIDTH];
    end

    assign sel_ok   = 32'(sel) < CHANNELS;
    assign ptr_last = (ptr_q == SEL_W'(CHANNELS - 1));

    // Explicit wrap keeps the pointer inside range for non-power-of-two channel counts.
    always_comb begin
        ptr_d = ptr_q;
        if (load_sel) begin
            if (sel_ok) begin
                ptr_d = sel;
            end
        end else if (mode) begin
            ptr_d = ptr_last ? '0 : ptr_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else if (hold) begin
            sel_err <= 1'b0;
        end else begin
            out       <= ch_data[ptr_q];
            out_ch    <= ptr_q;
            out_valid <= 1'b1;
            ptr_q     <= ptr_d;
            sel_err   <= load_sel && !sel_ok;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: a 4-channel and a 5-channel instance share control inputs; a queue-based
// scoreboard compares each edge against a behavioural model, plus directed sequence checks.
module tb_mux_scan;
    localparam int W = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    logic load_sel, mode, hold;

    logic [4*W-1:0] in4;
    logic [1:0]     sel4;
    logic [W-1:0]   out4;
    logic [1:0]     och4;
    logic           ov4, se4;

    logic [5*W-1:0] in5;
    logic [2:0]     sel5;
    logic [W-1:0]   out5;
    logic [2:0]     och5;
    logic           ov5, se5;

    mux_scan #(.WIDTH(W), .CHANNELS(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .in(in4), .sel(sel4), .load_sel(load_sel),
        .mode(mode), .hold(hold), .out(out4), .out_ch(och4), .out_valid(ov4), .sel_err(se4)
    );

    mux_scan #(.WIDTH(W), .CHANNELS(5)) dut5 (
        .clock(clock), .reset_n(reset_n), .in(in5), .sel(sel5), .load_sel(load_sel),
        .mode(mode), .hold(hold), .out(out5), .out_ch(och5), .out_valid(ov5), .sel_err(se5)
    );

    typedef struct {
        int ptr;
        int out;
        int ch;
        int valid;
        int err;
    } st_t;

    st_t m4, m5, e4, e5;
    st_t q4[$];
    st_t q5[$];
    logic [W-1:0] d4 [4];
    logic [W-1:0] d5 [5];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic st_t reset_state();
        st_t r;
        r.ptr = 0; r.out = 0; r.ch = 0; r.valid = 0; r.err = 0;
        return r;
    endfunction

    // Reference behaviour of one clock edge, straight from the channel-scan rules.
    function automatic st_t nxt(st_t s, int n, int sel, bit ld, bit md, bit hd, int dat);
        st_t r = s;
        r.err = 0;
        if (!hd) begin
            r.out   = dat;
            r.ch    = s.ptr;
            r.valid = 1;
            if (ld) begin
                if (sel < n) r.ptr = sel;
                else r.err = 1;
            end else if (md) begin
                r.ptr = (s.ptr + 1) % n;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic pack();
        for (int k = 0; k < 4; k++) in4[k*W +: W] = d4[k];
        for (int k = 0; k < 5; k++) in5[k*W +: W] = d5[k];
    endtask

    // Drive one edge's inputs, predict its result, return at the following negedge.
    task automatic cyc(input bit ld, input bit md, input bit hd, input int s4, input int s5);
        load_sel = ld;
        mode     = md;
        hold     = hd;
        sel4     = s4[1:0];
        sel5     = s5[2:0];
        pack();
        @(posedge clock);
        m4 = nxt(m4, 4, int'(sel4), ld, md, hd, int'(d4[m4.ptr]));
        m5 = nxt(m5, 5, int'(sel5), ld, md, hd, int'(d5[m5.ptr]));
        q4.push_back(m4);
        q5.push_back(m5);
        @(negedge clock);
    endtask

    // Reset pulse placed entirely between two rising edges.
    task automatic pulse_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out4", int'(out4), 0);
        chk("rst_valid4", int'(ov4), 0);
        chk("rst_ch4", int'(och4), 0);
        chk("rst_out5", int'(out5), 0);
        chk("rst_valid5", int'(ov5), 0);
        chk("rst_err5", int'(se5), 0);
        q4.delete();
        q5.delete();
        m4 = reset_state();
        m5 = reset_state();
        #1 reset_n = 1'b1;
    endtask

    always @(negedge clock) begin
        if (q4.size() > 0) begin
            e4 = q4.pop_front();
            chk("sb_out4", int'(out4), e4.out);
            chk("sb_ch4", int'(och4), e4.ch);
            chk("sb_valid4", int'(ov4), e4.valid);
            chk("sb_err4", int'(se4), e4.err);
        end
        if (q5.size() > 0) begin
            e5 = q5.pop_front();
            chk("sb_out5", int'(out5), e5.out);
            chk("sb_ch5", int'(och5), e5.ch);
            chk("sb_valid5", int'(ov5), e5.valid);
            chk("sb_err5", int'(se5), e5.err);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_ch[6]  = '{0, 1, 2, 3, 0, 1};
    int exp_out[6] = '{'h1111, 'h2222, 'h3333, 'h4444, 'h1111, 'h2222};

    initial begin
        reset_n  = 1'b0;
        load_sel = 1'b0;
        mode     = 1'b0;
        hold     = 1'b0;
        sel4     = '0;
        sel5     = '0;
        d4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int k = 0; k < 5; k++) d5[k] = 16'(16'hA000 + k);
        pack();
        m4 = reset_state();
        m5 = reset_state();
        #2;
        chk("init_out4", int'(out4), 0);
        chk("init_valid4", int'(ov4), 0);
        chk("init_err4", int'(se4), 0);
        chk("init_ch5", int'(och5), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Auto-scan sequence from reset.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 0, 0);
            chk("scan_ch", int'(och4), exp_ch[i]);
            chk("scan_out", int'(out4), exp_out[i]);
        end

        // Manual load of channel 2, then pointer static.
        cyc(1'b1, 1'b0, 1'b0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 0, 0);
            chk("load_out", int'(out4), 'h3333);
            chk("load_ch", int'(och4), 2);
        end

        // Out-of-range select on the 5-channel instance.
        cyc(1'b1, 1'b0, 1'b0, 2, 6);
        chk("bad_sel_err", int'(se5), 1);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        chk("bad_sel_err_drop", int'(se5), 0);
        chk("bad_sel_ptr", int'(och5), 0);
        cyc(1'b1, 1'b0, 1'b0, 2, 4);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        chk("wrap_ch4", int'(och5), 4);
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        chk("wrap_ch0", int'(och5), 0);

        // Hold overrides load and scan.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 3, 7);
            chk("hold_err", int'(se5), 0);
            chk("hold_ch5", int'(och5), 0);
        end
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        chk("resume_ch5", int'(och5), 1);

        // Load beats auto-scan on the same edge.
        cyc(1'b1, 1'b1, 1'b0, 1, 1);
        cyc(1'b0, 1'b0, 1'b0, 0, 0);
        chk("prec_ch4", int'(och4), 1);
        chk("prec_ch5", int'(och5), 1);

        // Asynchronous reset mid-scan with pointer at 3.
        cyc(1'b1, 1'b1, 1'b0, 3, 3);
        pulse_reset();
        cyc(1'b0, 1'b1, 1'b0, 0, 0);
        chk("post_rst_ch", int'(och4), 0);
        chk("post_rst_valid", int'(ov4), 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) begin
                for (int k = 0; k < 4; k++) d4[k] = 16'($urandom);
                for (int k = 0; k < 5; k++) d5[k] = 16'($urandom);
            end
            if ($urandom_range(60) == 0) pulse_reset();
            cyc($urandom_range(3) == 0, 1'($urandom), $urandom_range(7) == 0,
                int'($urandom_range(3)), int'($urandom_range(7)));
        end

        @(negedge clock);
        chk("queue4_drained", q4.size(), 0);
        chk("queue5_drained", q5.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
